// File: rtl/dma_pkg.sv
// Shared types and the descriptor chunk-size helper
// for the XDMA descriptor-bypass issuer.
package dma_pkg;

   localparam int DSC_LEN_MAX_W = 28;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] len;
   } dma_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ISSUE
   } issuer_state_t;

   // Bytes left before the next boundary, the cap and the remainder;
   // 33-bit math so a full 2^32 boundary distance cannot overflow.
   function automatic logic [31:0] chunk_len(
      input logic [31:0] rem,
      input logic [31:0] addr_lo,
      input logic [32:0] max_len,
      input logic [32:0] bnd
   );
      logic [32:0] room;
      logic [32:0] c;
      room = bnd - ({1'b0, addr_lo} & (bnd - 33'd1));
      c    = {1'b0, rem};
      if (max_len < c) c = max_len;
      if (room < c)    c = room;
      return c[31:0];
   endfunction

endpackage

// File: rtl/dma_desc_issuer.sv
// Splits host DMA commands into boundary-safe descriptors
// and drives them into the XDMA descriptor-bypass port.
module dma_desc_issuer
   import dma_pkg::*;
#(
   parameter int unsigned MAX_DESC_LEN = 65536,
   parameter int unsigned BOUNDARY     = 4096
) (
   input  logic        pcie_clk,
   input  logic        pcie_aresetn,
   input  logic        s_cmd_valid,
   output logic        s_cmd_ready,
   input  logic [63:0] s_cmd_addr,
   input  logic [31:0] s_cmd_len,
   input  logic        dsc_byp_ready,
   output logic [63:0] dsc_byp_addr,
   output logic [31:0] dsc_byp_len,
   output logic        dsc_byp_load,
   output logic        cmd_done,
   output logic [31:0] desc_cnt,
   output logic [31:0] cmd_cnt
);

   localparam logic [32:0] LEN_CAP = 33'(64'd1 << DSC_LEN_MAX_W);
   localparam logic [32:0] MAX_L =
      (33'(MAX_DESC_LEN) > LEN_CAP) ? LEN_CAP : 33'(MAX_DESC_LEN);
   localparam logic [32:0] BND = 33'(BOUNDARY);

   issuer_state_t state_q, state_d;
   logic [63:0]   cur_addr_q, cur_addr_d;
   logic [31:0]   rem_q, rem_d;
   logic [63:0]   dsc_addr_q, dsc_addr_d;
   logic [31:0]   dsc_len_q, dsc_len_d;
   logic          cmd_done_q, cmd_done_d;
   logic [31:0]   desc_cnt_q, desc_cnt_d;
   logic [31:0]   cmd_cnt_q, cmd_cnt_d;
   dma_cmd_t      cmd;

   assign cmd = '{addr: s_cmd_addr, len: s_cmd_len};

   always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
      if (!pcie_aresetn) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         dsc_addr_q <= '0;
         dsc_len_q  <= '0;
         cmd_done_q <= 1'b0;
         desc_cnt_q <= '0;
         cmd_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         dsc_addr_q <= dsc_addr_d;
         dsc_len_q  <= dsc_len_d;
         cmd_done_q <= cmd_done_d;
         desc_cnt_q <= desc_cnt_d;
         cmd_cnt_q  <= cmd_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      rem_d        = rem_q;
      dsc_addr_d   = dsc_addr_q;
      dsc_len_d    = dsc_len_q;
      cmd_done_d   = 1'b0;
      desc_cnt_d   = desc_cnt_q;
      cmd_cnt_d    = cmd_cnt_q;
      s_cmd_ready  = 1'b0;
      dsc_byp_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            s_cmd_ready = 1'b1;
            if (s_cmd_valid) begin
               cur_addr_d = cmd.addr;
               rem_d      = cmd.len;
               if (cmd.len == '0) begin
                  cmd_done_d = 1'b1;
                  cmd_cnt_d  = cmd_cnt_q + 32'd1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            dsc_addr_d = cur_addr_q;
            dsc_len_d  = chunk_len(rem_q, cur_addr_q[31:0], MAX_L, BND);
            state_d    = ISSUE;
         end
         ISSUE: begin
            dsc_byp_load = dsc_byp_ready;
            if (dsc_byp_ready) begin
               cur_addr_d = cur_addr_q + {32'd0, dsc_len_q};
               rem_d      = rem_q - dsc_len_q;
               desc_cnt_d = desc_cnt_q + 32'd1;
               if (rem_q == dsc_len_q) begin
                  cmd_done_d = 1'b1;
                  cmd_cnt_d  = cmd_cnt_q + 32'd1;
                  state_d    = IDLE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dsc_byp_addr = dsc_addr_q;
   assign dsc_byp_len  = (state_q == ISSUE) ? dsc_len_q : '0;
   assign cmd_done     = cmd_done_q;
   assign desc_cnt     = desc_cnt_q;
   assign cmd_cnt      = cmd_cnt_q;

endmodule
